// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StXfer,
    StTrail,
    StGap
  } spi_state_e;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period tick generator: counts 0..HALF_DIV-1 and pulses o_tick on the last count.
module spi_clkgen #(
  parameter int unsigned HALF_DIV = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(HALF_DIV - 1));
  assign o_tick = w_last & ~i_clr;

  // Every timed state exits on a tick, so wrapping here also zeroes the count on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0, MSB first, with lead/trail/gap timing around each byte.
// Optional back-to-back bursts without releasing ss when SPI_MASTER_BURST_EN is defined.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned HALF_DIV = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [SPI_WIDTH-1:0] i_d,
  output logic [SPI_WIDTH-1:0] o_q,
  output logic                 o_busy,
  output logic                 o_finished,
  output logic                 o_sck,
  output logic                 o_ss,
  output logic                 o_mosi,
  input  logic                 i_miso
);

  localparam int unsigned EDGES = 2 * SPI_WIDTH;

  spi_state_e           r_state;
  logic [SPI_WIDTH-1:0] r_tx;
  logic [SPI_WIDTH-1:0] r_rx;
  logic [SPI_WIDTH-1:0] r_q;
  logic [3:0]           r_edge;
  logic                 r_busy;
  logic                 r_finished;
  logic                 r_sck;
  logic                 r_ss;
  logic                 r_mosi;
  logic                 w_tick;
  logic                 w_clr;

  assign w_clr = (r_state == StIdle);

  spi_clkgen #(
    .HALF_DIV (HALF_DIV)
  ) u_clkgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_tx       <= '0;
      r_rx       <= '0;
      r_q        <= '0;
      r_edge     <= '0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_sck      <= 1'b0;
      r_ss       <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_tx    <= i_d;
            r_mosi  <= i_d[SPI_WIDTH-1];
            r_ss    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StLead;
          end
        end
        StLead: begin
          if (w_tick) begin
            r_edge  <= '0;
            r_state <= StXfer;
          end
        end
        StXfer: begin
          if (w_tick) begin
            r_edge <= r_edge + 4'd1;
            if (!r_sck) begin
              r_sck <= 1'b1;
              r_rx  <= {r_rx[SPI_WIDTH-2:0], i_miso};
            end else begin
              // mosi only moves on falling edges so the slave always samples a settled bit
              r_sck  <= 1'b0;
              r_tx   <= {r_tx[SPI_WIDTH-2:0], 1'b0};
              r_mosi <= r_tx[SPI_WIDTH-2];
            end
            if (r_edge == 4'(EDGES - 1)) begin
              r_state <= StTrail;
            end
          end
        end
        StTrail: begin
          if (w_tick) begin
            r_q        <= r_rx;
            r_finished <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
            if (i_start) begin
              r_tx    <= i_d;
              r_mosi  <= i_d[SPI_WIDTH-1];
              r_state <= StLead;
            end else begin
              r_ss    <= 1'b1;
              r_mosi  <= 1'b0;
              r_state <= StGap;
            end
`else
            r_ss    <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= StGap;
`endif
          end
        end
        StGap: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_q        = r_q;
  assign o_busy     = r_busy;
  assign o_finished = r_finished;
  assign o_sck      = r_sck;
  assign o_ss       = r_ss;
  assign o_mosi     = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: slave model, finished-driven monitor, protocol watchers.
module tb_spi_master;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] mosi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] d = 8'h00;
  logic       miso = 1'b0;
  logic [7:0] q;
  logic       busy, fin, sck, ss, mosi;

  logic       start2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic       miso2 = 1'b0;
  logic [7:0] q2;
  logic       busy2, fin2, sck2, ss2, mosi2;

  int n_checks = 0;
  int n_errors = 0;

  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] slave_q[$];
  logic [7:0] exp2_q[$];
  int         exp_ss[$];

  always #5 clk = ~clk;

  spi_master u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .i_d        (d),
    .o_q        (q),
    .o_busy     (busy),
    .o_finished (fin),
    .o_sck      (sck),
    .o_ss       (ss),
    .o_mosi     (mosi),
    .i_miso     (miso)
  );

  spi_master #(
    .HALF_DIV (2)
  ) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start2),
    .i_d        (d2),
    .o_q        (q2),
    .o_busy     (busy2),
    .o_finished (fin2),
    .o_sck      (sck2),
    .o_ss       (ss2),
    .o_mosi     (mosi2),
    .i_miso     (miso2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // Slave: loads a byte when ss falls (or a burst continues), shifts miso on sck falls.
  logic [7:0] s_sh = 8'h00, s_rx = 8'h00;
  int         s_rcnt = 0;
  logic       s_pss = 1'b1, s_psck = 1'b0;
  always @(negedge clk) begin
    if ((s_pss && !ss) || (fin && !ss)) begin
      s_sh   = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
      miso   = s_sh[7];
      s_rcnt = 0;
    end
    if (!ss && !s_psck && sck) begin
      s_rx = {s_rx[6:0], mosi};
      s_rcnt++;
      if (s_rcnt == 8) begin
        got_q.push_back(s_rx);
        s_rcnt = 0;
      end
    end
    if (!ss && s_psck && !sck) begin
      s_sh = {s_sh[6:0], 1'b0};
      miso = s_sh[7];
    end
    s_pss  = ss;
    s_psck = sck;
  end

  exp_t m_e;
  always @(negedge clk) begin
    if (fin) begin
      if (exp_q.size() == 0) begin
        flag("unexpected_finished");
      end else begin
        m_e = exp_q.pop_front();
        chk("q", q, m_e.q);
        chk("busy_at_finished", busy, 1);
        if (got_q.size() == 0) flag("mosi_byte_missing");
        else chk("mosi_byte", got_q.pop_front(), m_e.mosi);
      end
    end
  end

  int   ss_cnt = 0;
  logic ss_prev = 1'b1;
  always @(negedge clk) begin
    if (!ss) begin
      ss_cnt++;
    end else begin
      if (!ss_prev && exp_ss.size() > 0) chk("ss_low_cycles", ss_cnt, exp_ss.pop_front());
      ss_cnt = 0;
    end
    ss_prev = ss;
  end

  logic a_pfin = 1'b0, a_psck = 1'b0, a_pmosi = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ss && sck) flag("sck_high_while_ss_high");
      if (ss && mosi) flag("mosi_high_while_ss_high");
      if (fin && a_pfin) flag("finished_two_cycles");
      if (sck && !a_psck && (mosi !== a_pmosi)) flag("mosi_changed_on_rising");
      if (ss2 && sck2) flag("sck2_high_while_ss2_high");
    end
    a_pfin  = fin;
    a_psck  = sck;
    a_pmosi = mosi;
  end

  int   cyc2 = 0, last2 = 0, nr2 = 0;
  logic p_sck2 = 1'b0;
  always @(negedge clk) begin
    cyc2++;
    if (!ss2 && sck2 && !p_sck2) begin
      if (nr2 > 0) chk("sck2_period", cyc2 - last2, 4);
      last2 = cyc2;
      nr2++;
    end
    if (ss2) nr2 = 0;
    p_sck2 = sck2;
    if (fin2) begin
      if (exp2_q.size() == 0) flag("unexpected_finished2");
      else chk("q2", q2, exp2_q.pop_front());
    end
  end

  task automatic xfer_start(input logic [7:0] byte_d);
    @(negedge clk);
    start = 1'b1;
    d     = byte_d;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ss_after_start", ss, 0);
    chk("mosi_lead", mosi, byte_d[7]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) flag("timeout_wait_idle");
    repeat (2) @(negedge clk);
  endtask

  task automatic run2(input logic miso_v, input logic [7:0] expv);
    int n = 0;
    miso2 = miso_v;
    exp2_q.push_back(expv);
    @(negedge clk);
    start2 = 1'b1;
    d2     = 8'h5A;
    @(negedge clk);
    start2 = 1'b0;
    while (busy2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy2) flag("timeout_dut2");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   r, n, g;
    logic p;
    repeat (3) @(negedge clk);
    chk("reset_q", q, 8'h00);
    chk("reset_ss", ss, 1);
    chk("reset_sck", sck, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_finished", fin, 0);
    rst_n = 1'b1;

    // Basic byte: F2 out, 41 in.
    slave_q.push_back(8'h41);
    exp_q.push_back('{q: 8'h41, mosi: 8'hF2});
    exp_ss.push_back(90);
    xfer_start(8'hF2);
    wait_idle();

    // Second start and d change mid-transfer must be ignored.
    slave_q.push_back(8'h5A);
    exp_q.push_back('{q: 8'h5A, mosi: 8'hF2});
    exp_ss.push_back(90);
    xfer_start(8'hF2);
    repeat (18) @(negedge clk);
    start = 1'b1;
    d     = 8'h00;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid_transfer", busy, 1);
    wait_idle();

    // Reset after the 4th rising sck edge aborts the byte.
    slave_q.push_back(8'h99);
    xfer_start(8'hC3);
    r = 0;
    n = 0;
    p = sck;
    while (r < 4 && n < 1000) begin
      @(negedge clk);
      if (sck && !p) r++;
      p = sck;
      n++;
    end
    if (r < 4) flag("timeout_fourth_rise");
    rst_n = 1'b0;
    #1;
    chk("abort_ss", ss, 1);
    chk("abort_sck", sck, 0);
    chk("abort_busy", busy, 0);
    chk("abort_q", q, 8'h00);
    chk("abort_mosi", mosi, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    slave_q.push_back(8'h3C);
    exp_q.push_back('{q: 8'h3C, mosi: 8'hA5});
    exp_ss.push_back(90);
    xfer_start(8'hA5);
    wait_idle();

    // Back-to-back with start held high.
    slave_q.push_back(8'h11);
    slave_q.push_back(8'h22);
    exp_q.push_back('{q: 8'h11, mosi: 8'hA5});
    exp_q.push_back('{q: 8'h22, mosi: 8'h3C});
`ifdef SPI_MASTER_BURST_EN
    exp_ss.push_back(180);
`else
    exp_ss.push_back(90);
    exp_ss.push_back(90);
`endif
    @(negedge clk);
    start = 1'b1;
    d     = 8'hA5;
    @(negedge clk);
    d = 8'h3C;
    n = 0;
    while (!fin && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!fin) flag("timeout_first_finished");
    g = 0;
    n = 0;
    while (ss && n < 100) begin
      g++;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
`ifdef SPI_MASTER_BURST_EN
    chk("burst_gap_cycles", g, 0);
`else
    chk("gap_at_least_half_div", (g >= 5) ? 1 : 0, 1);
`endif
    chk("second_byte_ss_low", ss, 0);
    wait_idle();

    // HALF_DIV=2 instance: constant miso.
    run2(1'b1, 8'hFF);
    run2(1'b0, 8'h00);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("got_q_drained", got_q.size(), 0);
    chk("exp_ss_drained", exp_ss.size(), 0);
    chk("exp2_q_drained", exp2_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter HALF_DIV, default 5, clk cycles per SCK half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one byte transfer; sampled each clk.
REQ-005 d  input  8  transmit byte; captured when start is accepted.
REQ-006 q  output  8  last received byte; updated at end of transfer.
REQ-007 busy  output  1  high from start acceptance until the block can accept the next start.
REQ-008 finished  output  1  single-cycle pulse when q is updated.
REQ-009 sck  output  1  SPI clock; idles low (CPOL=0, CPHA=0).
REQ-010 ss  output  1  slave select, active low; idles high.
REQ-011 mosi  output  1  serial data out, MSB first.
REQ-012 miso  input  1  serial data in, MSB first; synchronous to sck, no extra synchronizer.

Function
REQ-013 State machine SHALL have states IDLE, LEAD, XFER, TRAIL, GAP.
REQ-014 IDLE: busy=0, ss=1, sck=0; start=1 SHALL capture d into tx shift register, go to LEAD, assert busy next cycle.
REQ-015 start while busy=1 SHALL be ignored; d changes after capture SHALL have no effect.
REQ-016 LEAD: ss=0, sck=0, mosi=tx[7], duration HALF_DIV cycles, then XFER.
REQ-017 XFER: sck toggles every HALF_DIV cycles, 16 edges total; rising edge samples miso into rx LSB (shift left); falling edge shifts tx left so mosi shows next bit.
REQ-018 mosi SHALL change only on sck falling edges or LEAD entry, never on a rising edge.
REQ-019 After 8th falling edge SHALL go to TRAIL: ss=0, sck=0 for HALF_DIV cycles.
REQ-020 TRAIL exit: ss=1, q<=rx, finished=1 for exactly one cycle, go to GAP.
REQ-021 GAP: ss=1, busy=1 for HALF_DIV cycles, then IDLE; ss low time per byte = 18*HALF_DIV cycles (90 at default).
REQ-022 mosi SHALL be 0 whenever ss=1.
REQ-023 Half-period counter SHALL reset to 0 on every state entry; no wrap beyond HALF_DIV-1.

Reset
REQ-024 reset low SHALL immediately force: state IDLE, ss=1, sck=0, mosi=0, busy=0, finished=0, q=8'h00, shift registers 0.
REQ-025 Reset mid-transfer SHALL abort with no finished pulse; first start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro SPI_MASTER_BURST_EN: when defined, start=1 in the TRAIL exit cycle SHALL capture d, pulse finished, update q, keep ss=0 and go to LEAD (skip GAP); busy stays high.
REQ-027 Without SPI_MASTER_BURST_EN, start in TRAIL exit SHALL be ignored and ss SHALL go high for ≥ HALF_DIV cycles between bytes.

Structure
REQ-028 Package spi_pkg SHALL hold the state enum type and constant SPI_WIDTH=8.
REQ-029 Sub-module spi_clkgen SHALL provide the half-period tick (counter, clear on state change); all else in spi_master.

Verification
REQ-030 Default HALF_DIV, d=8'hF2, slave model drives 8'h41 -> mosi bits 1,1,1,1,0,0,1,0 on rising edges; q=8'h41; one finished pulse; ss low 90 cycles.
REQ-031 start pulsed again 20 cycles into transfer with d=8'h00 -> ignored; byte still 8'hF2; single finished.
REQ-032 reset low after 4th rising sck edge -> ss=1, sck=0, busy=0 same cycle; no finished; next transfer 8'hA5 correct.
REQ-033 Back-to-back 8'hA5 then 8'h3C, start held high -> without macro ss high ≥5 cycles between; with SPI_MASTER_BURST_EN ss continuously low for 180 cycles, two finished pulses.
REQ-034 HALF_DIV=2, miso held 1 -> sck period 4 clk, q=8'hFF; miso held 0 -> q=8'h00.
REQ-035 Assertions: sck=0 whenever ss=1; finished never high for two consecutive cycles.
